strategy_switch_ctrl: RTL and testbench
=======================================

# strategy_switch_ctrl

Upstream controller that drives `strategy_sel` into `strategy_mux`, replacing a raw software register. It accepts strategy-change requests over a valid/ready handshake, validates them, and performs a glitch-free switch. Mux outputs are blanked for a guard window before and after the select changes, so no partial pulse from the old or new strategy leaks to the synchronization outputs.

## Interface
Parameters:
- `NUM_STRATEGIES`, 5: number of implemented strategies; valid selects are 0..NUM_STRATEGIES-1.
- `DEFAULT_SEL`, 0: value of `strategy_sel` out of reset. Must be < NUM_STRATEGIES.
- `GUARD_CYCLES`, 4: length of each blanking window in clock cycles; ≥1.

Ports:
- `clock` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `req_sel` in 8: requested strategy.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller can accept a request.
- `strategy_sel` out 8: registered select to `strategy_mux`.
- `blank` out 1: forces the mux outputs inactive while high; registered.
- `done` out 1: one-cycle pulse when a request completes.
- `err_invalid` out 1: sticky flag; set when an out-of-range request is rejected.
- `err_clear` in 1: clears `err_invalid`.
- `switch_count` out 16: count of completed real switches.

## Operation
- States: IDLE, PRE, POST.
  - IDLE drives `req_ready`=1; every other state drives it 0.
  - `req_ready` is a decode of the registered state.
- A request is accepted in a cycle where `req_valid` and `req_ready` are both 1. The accept is evaluated at the clock edge. Behaviour on accept:
  - `req_sel` ≥ NUM_STRATEGIES: request rejected. Set `err_invalid`, pulse `done` next cycle, stay in IDLE, leave `strategy_sel` unchanged.
  - `req_sel` == current `strategy_sel`: no-op. Pulse `done` next cycle, stay in IDLE, no blanking, no count.
  - Otherwise: latch `req_sel` into a pending register, load the guard counter with GUARD_CYCLES-1, and go to PRE.
- PRE:
  - `blank`=1.
  - Counter decrements each cycle.
  - When it reaches 0: load pending into `strategy_sel`, reload the counter, and go to POST.
- POST:
  - `blank`=1.
  - Counter decrements each cycle.
  - When it reaches 0: go to IDLE, pulse `done`, and increment `switch_count`.
- `switch_count` wraps from 0xFFFF to 0x0000.
- `err_invalid` setting versus `err_clear`:
  - If a set and `err_clear` occur in the same cycle, the set wins.
  - Otherwise `err_clear` clears the flag at the next edge.
- `req_valid` and `req_sel` are ignored outside IDLE. The requester must hold them until accepted.

## Timing
- Reset values:
  - State IDLE, `req_ready`=1.
  - `strategy_sel`=DEFAULT_SEL.
  - `blank`=0, `done`=0, `err_invalid`=0, `switch_count`=0.
- Reset asserted mid-switch aborts it: all outputs return to their reset values at the next edge, and the pending select is discarded.
- Real switch accepted at edge of cycle N (G = GUARD_CYCLES):
  - `blank` is high in cycles N+1 .. N+2G.
  - `strategy_sel` holds its old value through N+G and the new value from N+G+1.
  - `done` is high in cycle N+2G+1; `blank`=0 and `req_ready`=1 in that same cycle.
  - `switch_count` shows the new value from N+2G+1.
- Throughput:
  - A new request can be accepted in the `done` cycle.
  - Back-to-back real switches are spaced 2G+1 cycles apart.
- No-op or invalid request accepted at N: `done` is high at N+1, `req_ready` stays 1, and there is no gap.
- The select never changes while `blank`=0, and `blank` is high for at least G cycles on each side of the change.

## Test plan
- Reset: hold `reset` high 3 cycles, release → `strategy_sel`=0, `blank`=0, `req_ready`=1, `switch_count`=0.
- Real switch, G=4: request `req_sel`=2 accepted at cycle 10 → `blank` high in cycles 11–18, `strategy_sel`=0 through 14 and 2 from 15, `done` at 19, `switch_count`=1.
- No-op request:
  - Request `req_sel`=2 while `strategy_sel`=2 → `done` the next cycle.
  - `blank` never rises and `switch_count` is unchanged.
- Invalid request:
  - `req_sel`=7 with NUM_STRATEGIES=5 → `err_invalid`=1 and `done` pulses; `strategy_sel` is unchanged.
  - Assert `err_clear` and `req_valid` with 9 in the same cycle → `err_invalid` stays 1.
  - `err_clear` alone → `err_invalid`=0 next cycle.
- Back-to-back: hold `req_valid` with 1, then 3, then 4 → three switches spaced 9 cycles apart, `switch_count`=3, `req_ready` low during each PRE/POST.
- Reset during POST: assert `reset` 2 cycles after a switch to 3 → `strategy_sel`=0, `blank`=0, no `done` pulse, `switch_count`=0.

Source files
------------

// File: rtl/strategy_switch_ctrl.sv
// -----------------------------------------------------------------------------
// strategy_switch_ctrl
//
// Purpose: sits upstream of strategy_mux and owns its select. Requests for a new
// strategy arrive on a valid/ready handshake. Each request is either rejected
// (out of range), treated as a no-op (already selected), or carried out as a
// glitch-free switch. The mux is blanked for GUARD_CYCLES before the select
// changes and for GUARD_CYCLES after it.
//
// Ports:
//   clock        in   rising-edge clock
//   reset        in   synchronous, active-high
//   req_sel      in   [7:0] requested strategy
//   req_valid    in   request present
//   req_ready    out  high while the controller is idle and can take a request
//   strategy_sel out  [7:0] registered select into strategy_mux
//   blank        out  registered; forces the mux outputs inactive while high
//   done         out  one-cycle pulse when a request completes
//   err_invalid  out  sticky; set when an out-of-range request is rejected
//   err_clear    in   clears err_invalid (a simultaneous set wins)
//   switch_count out  [15:0] number of completed real switches, wraps
// -----------------------------------------------------------------------------
module strategy_switch_ctrl #(
    parameter int NUM_STRATEGIES = 5,
    parameter int DEFAULT_SEL    = 0,
    parameter int GUARD_CYCLES   = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  req_sel,
    input  logic        req_valid,
    output logic        req_ready,
    output logic [7:0]  strategy_sel,
    output logic        blank,
    output logic        done,
    output logic        err_invalid,
    input  logic        err_clear,
    output logic [15:0] switch_count
);

    localparam int            CW        = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD  = CW'(GUARD_CYCLES - 1);
    localparam logic [8:0]    SEL_LIMIT = 9'(NUM_STRATEGIES);
    localparam logic [7:0]    SEL_RESET = 8'(DEFAULT_SEL);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        POST = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [7:0]    pending, pending_nxt;
    logic [7:0]    sel_nxt;
    logic          done_nxt;
    logic          err_set;
    logic          count_inc;
    logic          accept;
    logic          sel_invalid;

    // The completed-switch counter is allowed to roll over.
    function automatic logic [15:0] wrap_inc(input logic [15:0] v);
        return v + 16'd1;
    endfunction

    assign req_ready   = (state == IDLE);
    assign accept      = req_valid && req_ready;
    // Widened by one bit so that NUM_STRATEGIES up to 256 compares correctly.
    assign sel_invalid = ({1'b0, req_sel} >= SEL_LIMIT);

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        pending_nxt = pending;
        sel_nxt     = strategy_sel;
        done_nxt    = 1'b0;
        err_set     = 1'b0;
        count_inc   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (sel_invalid) begin
                        err_set  = 1'b1;
                        done_nxt = 1'b1;
                    end else if (req_sel == strategy_sel) begin
                        done_nxt = 1'b1;
                    end else begin
                        pending_nxt = req_sel;
                        cnt_nxt     = CNT_LOAD;
                        state_nxt   = PRE;
                    end
                end
            end
            PRE: begin
                // The select changes only once the leading blank window has elapsed.
                if (cnt == '0) begin
                    sel_nxt   = pending;
                    cnt_nxt   = CNT_LOAD;
                    state_nxt = POST;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            POST: begin
                if (cnt == '0) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                    count_inc = 1'b1;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            strategy_sel <= SEL_RESET;
            blank        <= 1'b0;
            done         <= 1'b0;
            err_invalid  <= 1'b0;
            switch_count <= 16'd0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            strategy_sel <= sel_nxt;
            // Registered from the next state so blank is high exactly while in PRE/POST.
            blank        <= (state_nxt != IDLE);
            done         <= done_nxt;
            if (err_set) begin
                err_invalid <= 1'b1;
            end else if (err_clear) begin
                err_invalid <= 1'b0;
            end
            if (count_inc) begin
                switch_count <= wrap_inc(switch_count);
            end
        end
    end

    // The pending select is only read in PRE, so it needs no reset.
    always_ff @(posedge clock) begin
        pending <= pending_nxt;
    end

endmodule

// File: tb/tb_strategy_switch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_strategy_switch_ctrl
//
// Directed bench for strategy_switch_ctrl with the default parameters
// (NUM_STRATEGIES=5, DEFAULT_SEL=0, GUARD_CYCLES=4). Inputs are driven and
// outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_strategy_switch_ctrl;

    localparam int G = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  req_sel;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  strategy_sel;
    logic        blank;
    logic        done;
    logic        err_invalid;
    logic        err_clear;
    logic [15:0] switch_count;

    int checks = 0;
    int errors = 0;

    strategy_switch_ctrl #(
        .NUM_STRATEGIES(5),
        .DEFAULT_SEL   (0),
        .GUARD_CYCLES  (G)
    ) dut (
        .clock       (clk),
        .reset       (reset),
        .req_sel     (req_sel),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .strategy_sel(strategy_sel),
        .blank       (blank),
        .done        (done),
        .err_invalid (err_invalid),
        .err_clear   (err_clear),
        .switch_count(switch_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called in the cycle where a real switch request is presented (cycle N).
    // Walks cycles N+1 .. N+2G+1 and returns in the done cycle; the next
    // request is presented in cycle N+1 and is ignored until the done cycle.
    task automatic run_switch(input logic [7:0] old_sel, input logic [7:0] new_sel,
                              input logic [15:0] cnt_before,
                              input logic nxt_valid, input logic [7:0] nxt_sel);
        chk("sw_ready_at_accept", {31'd0, req_ready}, 32'd1);
        for (int k = 1; k <= 2 * G + 1; k++) begin
            tick();
            if (k == 1) begin
                req_valid = nxt_valid;
                req_sel   = nxt_sel;
            end
            chk($sformatf("sw%0d_blank_k%0d", new_sel, k), {31'd0, blank},
                (k <= 2 * G) ? 32'd1 : 32'd0);
            chk($sformatf("sw%0d_sel_k%0d", new_sel, k), {24'd0, strategy_sel},
                (k <= G) ? {24'd0, old_sel} : {24'd0, new_sel});
            chk($sformatf("sw%0d_done_k%0d", new_sel, k), {31'd0, done},
                (k == 2 * G + 1) ? 32'd1 : 32'd0);
            chk($sformatf("sw%0d_ready_k%0d", new_sel, k), {31'd0, req_ready},
                (k == 2 * G + 1) ? 32'd1 : 32'd0);
            chk($sformatf("sw%0d_count_k%0d", new_sel, k), {16'd0, switch_count},
                (k == 2 * G + 1) ? {16'd0, cnt_before + 16'd1} : {16'd0, cnt_before});
        end
    endtask

    initial begin
        reset     = 1'b1;
        req_sel   = 8'd0;
        req_valid = 1'b0;
        err_clear = 1'b0;

        // Reset held for 3 cycles
        tick();
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("rst_sel",   {24'd0, strategy_sel}, 32'd0);
        chk("rst_blank", {31'd0, blank},        32'd0);
        chk("rst_ready", {31'd0, req_ready},    32'd1);
        chk("rst_done",  {31'd0, done},         32'd0);
        chk("rst_err",   {31'd0, err_invalid},  32'd0);
        chk("rst_count", {16'd0, switch_count}, 32'd0);

        // Real switch 0 -> 2
        req_valid = 1'b1;
        req_sel   = 8'd2;
        run_switch(8'd0, 8'd2, 16'd0, 1'b0, 8'd2);

        // No-op request accepted in the done cycle
        req_valid = 1'b1;
        req_sel   = 8'd2;
        tick();
        req_valid = 1'b0;
        chk("noop_done",  {31'd0, done},         32'd1);
        chk("noop_blank", {31'd0, blank},        32'd0);
        chk("noop_ready", {31'd0, req_ready},    32'd1);
        chk("noop_sel",   {24'd0, strategy_sel}, 32'd2);
        chk("noop_count", {16'd0, switch_count}, 32'd1);
        tick();
        chk("noop_done_end",  {31'd0, done},  32'd0);
        chk("noop_blank_end", {31'd0, blank}, 32'd0);

        // Invalid request (7 >= 5)
        req_valid = 1'b1;
        req_sel   = 8'd7;
        tick();
        req_valid = 1'b0;
        chk("inv_done",  {31'd0, done},         32'd1);
        chk("inv_err",   {31'd0, err_invalid},  32'd1);
        chk("inv_sel",   {24'd0, strategy_sel}, 32'd2);
        chk("inv_blank", {31'd0, blank},        32'd0);
        chk("inv_ready", {31'd0, req_ready},    32'd1);
        tick();
        chk("inv_done_end", {31'd0, done},        32'd0);
        chk("inv_err_held", {31'd0, err_invalid}, 32'd1);

        // Set and clear in the same cycle: set wins
        err_clear = 1'b1;
        req_valid = 1'b1;
        req_sel   = 8'd9;
        tick();
        err_clear = 1'b0;
        req_valid = 1'b0;
        chk("setclr_err",  {31'd0, err_invalid}, 32'd1);
        chk("setclr_done", {31'd0, done},        32'd1);
        tick();
        chk("setclr_err_after", {31'd0, err_invalid}, 32'd1);

        // Clear alone
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        chk("clr_err",  {31'd0, err_invalid}, 32'd0);
        chk("clr_done", {31'd0, done},        32'd0);

        // Back-to-back switches 2 -> 1 -> 3 -> 4
        req_valid = 1'b1;
        req_sel   = 8'd1;
        run_switch(8'd2, 8'd1, 16'd1, 1'b1, 8'd3);
        run_switch(8'd1, 8'd3, 16'd2, 1'b1, 8'd4);
        run_switch(8'd3, 8'd4, 16'd3, 1'b0, 8'd4);

        // Reset during POST of a switch 4 -> 3
        req_valid = 1'b1;
        req_sel   = 8'd3;
        for (int k = 1; k <= G + 2; k++) begin
            tick();
            req_valid = 1'b0;
        end
        chk("abort_sel_in_post",   {24'd0, strategy_sel}, 32'd3);
        chk("abort_blank_in_post", {31'd0, blank},        32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_sel",   {24'd0, strategy_sel}, 32'd0);
        chk("abort_blank", {31'd0, blank},        32'd0);
        chk("abort_done",  {31'd0, done},         32'd0);
        chk("abort_ready", {31'd0, req_ready},    32'd1);
        chk("abort_count", {16'd0, switch_count}, 32'd0);
        for (int k = 1; k <= G; k++) begin
            tick();
            chk($sformatf("abort_no_done_%0d", k),  {31'd0, done},  32'd0);
            chk($sformatf("abort_no_blank_%0d", k), {31'd0, blank}, 32'd0);
        end
        chk("abort_sel_final", {24'd0, strategy_sel}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
